fila_ctrl: RTL and testbench
============================

FILA_CTRL -- requirements
Module: fila_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, queue capacity in words.
REQ-002 Parameter LEN_W, default 4, width of occupancy input, holds 0..DEPTH.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clock_10KHz  in  1  queue-domain clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-low (0 = reset).
REQ-006 data_ready  in  1  deserializer word available; level, held until ack_out seen.
REQ-007 ack_out  out  1  one-cycle ack pulse to deserializer ack_in.
REQ-008 dequeue_req  in  1  consumer read request; level, held until dequeue_grant seen.
REQ-009 dequeue_grant  out  1  one-cycle pulse: requested word has left the queue.
REQ-010 enqueue_out  out  1  one-cycle pulse to queue enqueue_in.
REQ-011 dequeue_out  out  1  one-cycle pulse to queue dequeue_in.
REQ-012 len_in  in  LEN_W  queue occupancy (len_out of queue).
REQ-013 full_out  out  1  combinational, len_in == DEPTH.
REQ-014 empty_out  out  1  combinational, len_in == 0.
REQ-015 busy_out  out  1  high in any state other than IDLE.
REQ-016 xfer_count  out  8  enqueues completed, wraps 255->0.
REQ-017 err_out  out  1  sticky timeout flag (see Configuration).

Function
REQ-018 FSM states SHALL be IDLE, ENQ, WAIT_ENQ, ACK, DEQ, WAIT_DEQ, GRANT, RELEASE.
REQ-019 IDLE: eligible enqueue = data_ready & !full_out; eligible dequeue = dequeue_req & !empty_out.
REQ-020 Only enqueue eligible -> ENQ; only dequeue eligible -> DEQ; neither -> stay IDLE.
REQ-021 Both eligible: serve the kind NOT served last (round-robin); first contention after reset serves enqueue.
REQ-022 ENQ: enqueue_out=1 for exactly one cycle; snapshot len_in; -> WAIT_ENQ.
REQ-023 WAIT_ENQ: stay until len_in == snapshot+1, then -> ACK.
REQ-024 ACK: ack_out=1 one cycle; xfer_count increments; -> RELEASE.
REQ-025 DEQ: dequeue_out=1 one cycle; snapshot len_in; -> WAIT_DEQ.
REQ-026 WAIT_DEQ: stay until len_in == snapshot-1, then -> GRANT.
REQ-027 GRANT: dequeue_grant=1 one cycle; -> RELEASE.
REQ-028 RELEASE: wait until the request just served is low, then -> IDLE; prevents double service of one held request.
REQ-029 Minimum enqueue latency data_ready high -> ack_out high = 3 cycles (ENQ, WAIT_ENQ, ACK) when queue updates len one cycle after the pulse.
REQ-030 Queue full: data_ready held indefinitely, no enqueue_out, no ack_out; serviced once len_in < DEPTH.
REQ-031 Queue empty: dequeue_req held indefinitely without dequeue_out.
REQ-032 enqueue_out and dequeue_out SHALL never be high in the same cycle.
REQ-033 All pulse outputs registered; no combinational path from inputs to pulse outputs.

Reset
REQ-034 reset low: state=IDLE; ack_out, dequeue_grant, enqueue_out, dequeue_out=0; xfer_count=0; err_out=0; round-robin pointer=enqueue-preferred; immediate, clock-independent.
REQ-035 Reset mid-transfer aborts it; no ack_out or dequeue_grant is issued for the aborted operation.
REQ-036 First state change permitted on the first rising clock_10KHz edge after reset returns high.

Configuration
REQ-037 Macro FILA_CTRL_TIMEOUT_EN: when defined, a 4-bit counter runs in WAIT_ENQ/WAIT_DEQ; on the 16th cycle without the expected len_in change, err_out sets (sticky until reset) and FSM -> IDLE with no ack/grant.
REQ-038 Without FILA_CTRL_TIMEOUT_EN: WAIT states wait indefinitely, no counter exists, err_out tied 0.

Verification
REQ-039 len_in=0, data_ready=1, queue model updates len next cycle -> enqueue_out pulse cycle 1, ack_out pulse cycle 3, xfer_count=1, len_in=1.
REQ-040 len_in=8, data_ready=1 for 20 cycles -> no enqueue_out/ack_out; drop len_in to 7 -> enqueue_out next cycle.
REQ-041 len_in=3, data_ready and dequeue_req both held high -> service order enqueue, dequeue, enqueue; never both pulses in one cycle.
REQ-042 len_in=0, dequeue_req=1 -> no dequeue_out; data_ready enqueue -> then dequeue_out, dequeue_grant, len_in returns 0.
REQ-043 reset low during WAIT_ENQ -> all outputs 0 immediately, no ack_out after release; xfer_count=0.
REQ-044 FILA_CTRL_TIMEOUT_EN defined, len_in frozen after enqueue_out -> err_out=1 16 cycles later, FSM IDLE, no ack_out; undefined -> FSM stays WAIT_ENQ, err_out=0.

Source files
------------

// File: rtl/fila_ctrl.sv
// Handshake controller between a deserializer, a word queue and a consumer.
// Optional watchdog on the WAIT states: define FILA_CTRL_TIMEOUT_EN.
module fila_ctrl #(
  parameter int DEPTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clock_10KHz,
  input  logic             reset,
  input  logic             data_ready,
  output logic             ack_out,
  input  logic             dequeue_req,
  output logic             dequeue_grant,
  output logic             enqueue_out,
  output logic             dequeue_out,
  input  logic [LEN_W-1:0] len_in,
  output logic             full_out,
  output logic             empty_out,
  output logic             busy_out,
  output logic [7:0]       xfer_count,
  output logic             err_out
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ENQ      = 3'd1,
    WAIT_ENQ = 3'd2,
    ACK      = 3'd3,
    DEQ      = 3'd4,
    WAIT_DEQ = 3'd5,
    GRANT    = 3'd6,
    RELEASE  = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] snap_q, snap_d;
  logic             last_deq_q, last_deq_d;
  logic [7:0]       xfer_q, xfer_d;
  logic             enq_q, deq_q, ack_q, grant_q;
  logic             enq_ok_s, deq_ok_s;
  logic             enq_hit_s, deq_hit_s;
  logic             timeout_s;

  assign full_out   = (len_in == LEN_W'(DEPTH));
  assign empty_out  = (len_in == {LEN_W{1'b0}});
  assign enq_ok_s   = data_ready & ~full_out;
  assign deq_ok_s   = dequeue_req & ~empty_out;
  assign enq_hit_s  = (len_in == (snap_q + LEN_W'(1'b1)));
  assign deq_hit_s  = (len_in == (snap_q - LEN_W'(1'b1)));

  assign busy_out      = (state_q != IDLE);
  assign enqueue_out   = enq_q;
  assign dequeue_out   = deq_q;
  assign ack_out       = ack_q;
  assign dequeue_grant = grant_q;
  assign xfer_count    = xfer_q;

`ifdef FILA_CTRL_TIMEOUT_EN
  logic [3:0] tmo_q, tmo_d;
  logic       err_q;

  assign timeout_s = (tmo_q == 4'd15);
  assign err_out   = err_q;

  // Cycles spent in a WAIT state; cleared elsewhere so every wait starts from zero.
  always_comb begin
    tmo_d = 4'd0;
    if ((state_q == WAIT_ENQ) || (state_q == WAIT_DEQ)) begin
      tmo_d = tmo_q + 4'd1;
    end else begin
      tmo_d = 4'd0;
    end
  end

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clock_10KHz or negedge reset) begin
    if (!reset) begin
      tmo_q <= 4'd0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      if (((state_q == WAIT_ENQ) || (state_q == WAIT_DEQ)) && (state_d == IDLE)) begin
        err_q <= 1'b1;
      end else begin
        err_q <= err_q;
      end
    end
  end
`else
  assign timeout_s = 1'b0;
  assign err_out   = 1'b0;
`endif

  // Next-state logic; last_deq_q doubles as round-robin pointer and as the
  // record of which request RELEASE must see drop.
  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    last_deq_d = last_deq_q;
    xfer_d     = xfer_q;
    case (state_q)
      IDLE: begin
        if (enq_ok_s && (!deq_ok_s || last_deq_q)) begin
          state_d    = ENQ;
          last_deq_d = 1'b0;
        end else if (deq_ok_s) begin
          state_d    = DEQ;
          last_deq_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ENQ: begin
        snap_d  = len_in;
        state_d = WAIT_ENQ;
      end
      WAIT_ENQ: begin
        // Count moves with the ack so both become visible in the ACK cycle.
        if (enq_hit_s) begin
          state_d = ACK;
          xfer_d  = xfer_q + 8'd1;
        end else if (timeout_s) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_ENQ;
        end
      end
      ACK: begin
        state_d = RELEASE;
      end
      DEQ: begin
        snap_d  = len_in;
        state_d = WAIT_DEQ;
      end
      WAIT_DEQ: begin
        if (deq_hit_s) begin
          state_d = GRANT;
        end else if (timeout_s) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_DEQ;
        end
      end
      GRANT: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        if (last_deq_q ? !dequeue_req : !data_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RELEASE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, bookkeeping and registered pulse outputs decoded from the next state.
  always_ff @(posedge clock_10KHz or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      snap_q     <= {LEN_W{1'b0}};
      last_deq_q <= 1'b1;
      xfer_q     <= 8'd0;
      enq_q      <= 1'b0;
      deq_q      <= 1'b0;
      ack_q      <= 1'b0;
      grant_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      last_deq_q <= last_deq_d;
      xfer_q     <= xfer_d;
      enq_q      <= (state_d == ENQ);
      deq_q      <= (state_d == DEQ);
      ack_q      <= (state_d == ACK);
      grant_q    <= (state_d == GRANT);
    end
  end

endmodule

// File: tb/tb_fila_ctrl.sv
// Directed bench for fila_ctrl: a queue model that moves len one cycle after each
// pulse, a per-cycle transaction-level check, and literal timing expectations.
module tb_fila_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       data_ready = 1'b0;
  logic       dequeue_req = 1'b0;
  logic [3:0] len_in = 4'd0;
  logic       ack_out, dequeue_grant, enqueue_out, dequeue_out;
  logic       full_out, empty_out, busy_out, err_out;
  logic [7:0] xfer_count;

  int n_tests = 0;
  int n_fail  = 0;

  // queue model and handshake agents
  logic en_prev = 1'b0, de_prev = 1'b0, freeze = 1'b0;
  logic auto_enq = 1'b0, auto_deq = 1'b0;
  int   dr_hold = 0, dq_hold = 0;

  // transaction-level expectation state
  logic       enq_h1 = 1'b0, enq_h2 = 1'b0, deq_h1 = 1'b0, deq_h2 = 1'b0, upd_h1 = 1'b0;
  logic [7:0] exp_xfer = 8'd0;

  fila_ctrl dut (
    .clock_10KHz  (clk),
    .reset        (rst_n),
    .data_ready   (data_ready),
    .ack_out      (ack_out),
    .dequeue_req  (dequeue_req),
    .dequeue_grant(dequeue_grant),
    .enqueue_out  (enqueue_out),
    .dequeue_out  (dequeue_out),
    .len_in       (len_in),
    .full_out     (full_out),
    .empty_out    (empty_out),
    .busy_out     (busy_out),
    .xfer_count   (xfer_count),
    .err_out      (err_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // An enqueue/dequeue pulse whose len change arrived the next cycle must be
  // acknowledged/granted exactly two cycles after the pulse; nothing else may be.
  task automatic model_check(input logic dr, input logic dq, input logic [3:0] ln, input logic upd);
    logic exp_ack, exp_grant;
    exp_ack   = enq_h2 && upd_h1;
    exp_grant = deq_h2 && upd_h1;
    if (exp_ack) exp_xfer = exp_xfer + 8'd1;
    chk("ack_out", 32'(ack_out), 32'(exp_ack));
    chk("dequeue_grant", 32'(dequeue_grant), 32'(exp_grant));
    chk("xfer_count", 32'(xfer_count), 32'(exp_xfer));
    chk("full_out", 32'(full_out), 32'(len_in == 4'd8));
    chk("empty_out", 32'(empty_out), 32'(len_in == 4'd0));
    chk("pulse_exclusive", 32'(enqueue_out & dequeue_out), 32'd0);
    if (enqueue_out) chk("enq_eligible", 32'(dr && (ln != 4'd8)), 32'd1);
    if (dequeue_out) chk("deq_eligible", 32'(dq && (ln != 4'd0)), 32'd1);
    if (enqueue_out | dequeue_out | ack_out | dequeue_grant) chk("busy_with_pulse", 32'(busy_out), 32'd1);
`ifndef FILA_CTRL_TIMEOUT_EN
    chk("err_out", 32'(err_out), 32'd0);
`endif
    enq_h2 = enq_h1; enq_h1 = enqueue_out;
    deq_h2 = deq_h1; deq_h1 = dequeue_out;
    upd_h1 = upd;
  endtask

  task automatic step();
    logic s_dr, s_dq, upd;
    logic [3:0] s_ln;
    s_dr = data_ready; s_dq = dequeue_req; s_ln = len_in;
    @(posedge clk); #1;
    upd = !freeze;
    if (upd && en_prev) len_in = len_in + 4'd1;
    if (upd && de_prev) len_in = len_in - 4'd1;
    en_prev = enqueue_out; de_prev = dequeue_out;
    if (auto_enq) begin
      if (ack_out) begin data_ready = 1'b0; dr_hold = 1; end
      else if (dr_hold > 0) dr_hold--;
      else data_ready = 1'b1;
    end
    if (auto_deq) begin
      if (dequeue_grant) begin dequeue_req = 1'b0; dq_hold = 1; end
      else if (dq_hold > 0) dq_hold--;
      else dequeue_req = 1'b1;
    end
    @(negedge clk);
    model_check(s_dr, s_dq, s_ln, upd);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    data_ready = 1'b0; dequeue_req = 1'b0; freeze = 1'b0;
    auto_enq = 1'b0; auto_deq = 1'b0; dr_hold = 0; dq_hold = 0;
    en_prev = 1'b0; de_prev = 1'b0;
    enq_h1 = 1'b0; enq_h2 = 1'b0; deq_h1 = 1'b0; deq_h2 = 1'b0; upd_h1 = 1'b0;
    exp_xfer = 8'd0;
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int t_enq, t_ack, n_enq, n_deq, n_ack, n_grant, n_ord, i_enq, i_deq, t_err;
    logic ord [0:2];

    // reset values
    #3;
    chk("rst_ack", 32'(ack_out), 32'd0);
    chk("rst_grant", 32'(dequeue_grant), 32'd0);
    chk("rst_enq", 32'(enqueue_out), 32'd0);
    chk("rst_deq", 32'(dequeue_out), 32'd0);
    chk("rst_xfer", 32'(xfer_count), 32'd0);
    chk("rst_err", 32'(err_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_empty", 32'(empty_out), 32'd1);
    apply_reset();

    // single enqueue into an empty queue; held data_ready is served once
    len_in = 4'd0; data_ready = 1'b1;
    t_enq = 0; t_ack = 0; n_enq = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (enqueue_out) begin n_enq++; if (t_enq == 0) t_enq = i; end
      if (ack_out && t_ack == 0) begin
        t_ack = i;
        chk("A_xfer_at_ack", 32'(xfer_count), 32'd1);
        chk("A_len_at_ack", 32'(len_in), 32'd1);
      end
    end
    chk("A_enq_cycle", 32'(t_enq), 32'd1);
    chk("A_ack_cycle", 32'(t_ack), 32'd3);
    chk("A_single_service", 32'(n_enq), 32'd1);
    chk("A_busy_in_release", 32'(busy_out), 32'd1);
    data_ready = 1'b0;
    step();
    chk("A_idle_after_drop", 32'(busy_out), 32'd0);

    // full queue blocks enqueue until space appears
    len_in = 4'd8; data_ready = 1'b1; n_enq = 0; n_ack = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (enqueue_out) n_enq++;
      if (ack_out) n_ack++;
    end
    chk("B_full_no_enq", 32'(n_enq), 32'd0);
    chk("B_full_no_ack", 32'(n_ack), 32'd0);
    chk("B_full_idle", 32'(busy_out), 32'd0);
    len_in = 4'd7;
    step();
    chk("B_enq_after_space", 32'(enqueue_out), 32'd1);
    step(); step();
    chk("B_ack", 32'(ack_out), 32'd1);
    chk("B_xfer", 32'(xfer_count), 32'd2);
    data_ready = 1'b0;
    step(); step();
    chk("B_idle", 32'(busy_out), 32'd0);

    // contention: round-robin starting with enqueue after reset
    apply_reset();
    len_in = 4'd3; auto_enq = 1'b1; auto_deq = 1'b1;
    data_ready = 1'b1; dequeue_req = 1'b1; n_ord = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if ((enqueue_out || dequeue_out) && n_ord < 3) begin
        ord[n_ord] = enqueue_out;
        n_ord++;
      end
    end
    chk("C_services", 32'(n_ord), 32'd3);
    chk("C_first_enq", 32'(ord[0]), 32'd1);
    chk("C_second_deq", 32'(ord[1]), 32'd0);
    chk("C_third_enq", 32'(ord[2]), 32'd1);
    auto_enq = 1'b0; auto_deq = 1'b0; data_ready = 1'b0; dequeue_req = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("C_idle", 32'(busy_out), 32'd0);

    // empty queue blocks dequeue until an enqueue lands
    len_in = 4'd0; dequeue_req = 1'b1; n_deq = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (dequeue_out) n_deq++;
    end
    chk("D_empty_no_deq", 32'(n_deq), 32'd0);
    data_ready = 1'b1; n_grant = 0; i_enq = 0; i_deq = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (enqueue_out && i_enq == 0) i_enq = i;
      if (dequeue_out) begin n_deq++; if (i_deq == 0) i_deq = i; end
      if (ack_out) data_ready = 1'b0;
      if (dequeue_grant) begin n_grant++; dequeue_req = 1'b0; end
    end
    chk("D_enq_cycle", 32'(i_enq), 32'd1);
    chk("D_deq_after_enq", 32'(i_deq > i_enq), 32'd1);
    chk("D_deq_count", 32'(n_deq), 32'd1);
    chk("D_grant_count", 32'(n_grant), 32'd1);
    chk("D_len_back_to_0", 32'(len_in), 32'd0);
    chk("D_idle", 32'(busy_out), 32'd0);

    // reset while waiting for the queue to move
    len_in = 4'd2; data_ready = 1'b1;
    step(); step();
    chk("E_busy_in_wait", 32'(busy_out), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("E_rst_ack", 32'(ack_out), 32'd0);
    chk("E_rst_grant", 32'(dequeue_grant), 32'd0);
    chk("E_rst_enq", 32'(enqueue_out), 32'd0);
    chk("E_rst_deq", 32'(dequeue_out), 32'd0);
    chk("E_rst_busy", 32'(busy_out), 32'd0);
    chk("E_rst_xfer", 32'(xfer_count), 32'd0);
    apply_reset();
    n_ack = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ack_out) n_ack++;
    end
    chk("E_no_ack_after_abort", 32'(n_ack), 32'd0);
    chk("E_xfer_zero", 32'(xfer_count), 32'd0);

    // queue never moves after the enqueue pulse
    len_in = 4'd1; freeze = 1'b1; data_ready = 1'b1;
    n_enq = 0; n_ack = 0; t_err = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (enqueue_out) n_enq++;
      if (ack_out) n_ack++;
      if (err_out && t_err == 0) begin t_err = i; data_ready = 1'b0; end
    end
    chk("F_one_enq", 32'(n_enq), 32'd1);
    chk("F_no_ack", 32'(n_ack), 32'd0);
`ifdef FILA_CTRL_TIMEOUT_EN
    chk("F_err_set", 32'(err_out), 32'd1);
    chk("F_err_timing", 32'((t_err >= 17) && (t_err <= 19)), 32'd1);
    chk("F_idle_after_timeout", 32'(busy_out), 32'd0);
`else
    chk("F_err_clear", 32'(err_out), 32'd0);
    chk("F_still_waiting", 32'(busy_out), 32'd1);
`endif
    apply_reset();
    chk("F_err_cleared_by_reset", 32'(err_out), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
